// File: rtl/fwd_pkg.sv
// Shared types and constants for the EX-stage forwarding / load-use hazard controller.
package fwd_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 16;

  localparam logic [SEL_W-1:0] FWD_RF  = 2'b00;
  localparam logic [SEL_W-1:0] FWD_WB  = 2'b01;
  localparam logic [SEL_W-1:0] FWD_MEM = 2'b10;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
  localparam logic [CNT_W-1:0] CNT_MAX  = 16'hFFFF;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
  } slot_t;

  // Select for one source operand; the younger EX/MEM producer wins over MEM/WB.
  function automatic logic [SEL_W-1:0] fwd_sel(input slot_t ex_s, input slot_t mem_s,
                                               input logic [REG_W-1:0] rs);
    if (ex_s.regwrite && (ex_s.rd != REG_ZERO) && (ex_s.rd == rs)) begin
      return FWD_MEM;
    end else if (mem_s.regwrite && (mem_s.rd != REG_ZERO) && (mem_s.rd == rs)) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/fwd_slot.sv
// One pipeline shadow slot {rd, regwrite, memread}; a bubble loads all zeros.
import fwd_pkg::*;

module fwd_slot (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  bubble_i,
  input  slot_t d_i,
  output slot_t q_o
);

  slot_t slot_q;
  slot_t slot_d;

  always_comb begin
    slot_d = d_i;
    if (bubble_i) begin
      slot_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign q_o = slot_q;

endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding select and load-use stall generation for the EX stage, with a
// saturating stall-cycle counter.
import fwd_pkg::*;

module fwd_ctrl (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  input  logic [REG_W-1:0] id_rd_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             flush_i,
  output logic [SEL_W-1:0] fwd_a_o,
  output logic [SEL_W-1:0] fwd_b_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  slot_t            id_slot;
  slot_t            ex_q;
  slot_t            mem_q;
  slot_t            wb_q;
  logic             stall;
  logic             bubble;
  logic             wb_unused;
  logic [SEL_W-1:0] fwd_a_q, fwd_a_d;
  logic [SEL_W-1:0] fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign id_slot = '{rd: id_rd_i, regwrite: id_regwrite_i, memread: id_memread_i};

  // Load in EX feeding the instruction in ID; a taken branch discards ID, so no stall.
  assign stall = ex_q.memread && (ex_q.rd != REG_ZERO) && !flush_i &&
                 ((ex_q.rd == id_rs1_i) || (ex_q.rd == id_rs2_i));
  assign bubble = stall || flush_i;

  fwd_slot u_slot_ex (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .bubble_i (bubble),
    .d_i      (id_slot),
    .q_o      (ex_q)
  );

  fwd_slot u_slot_mem (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .bubble_i (1'b0),
    .d_i      (ex_q),
    .q_o      (mem_q)
  );

  fwd_slot u_slot_wb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .bubble_i (1'b0),
    .d_i      (mem_q),
    .q_o      (wb_q)
  );

  // WB is tracked for completeness; the register file write-through covers that distance.
  assign wb_unused = ^wb_q;

  always_comb begin
    fwd_a_d     = FWD_RF;
    fwd_b_d     = FWD_RF;
    stall_cnt_d = stall_cnt_q;
    if (!bubble) begin
      fwd_a_d = fwd_sel(ex_q, mem_q, id_rs1_i);
      fwd_b_d = fwd_sel(ex_q, mem_q, id_rs2_i);
    end
    if (stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= '0;
    end else begin
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_a_o     = fwd_a_q;
  assign fwd_b_o     = fwd_b_q;
  assign stall_o     = stall;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed bench for fwd_ctrl: forwarding selects, load-use stalls, flush, reset, saturation.
module tb_fwd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_regwrite, id_memread, flush;
  logic [1:0]  fwd_a, fwd_b;
  logic        stall;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  fwd_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_rd_i       (id_rd),
    .id_regwrite_i (id_regwrite),
    .id_memread_i  (id_memread),
    .flush_i       (flush),
    .fwd_a_o       (fwd_a),
    .fwd_b_o       (fwd_b),
    .stall_o       (stall),
    .stall_cnt_o   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic present(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rw, input logic mr);
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ex(input string tag, input logic [1:0] ea, input logic [1:0] eb);
    chk({tag, "_a"}, 16'(fwd_a), 16'(ea));
    chk({tag, "_b"}, 16'(fwd_b), 16'(eb));
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    present(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_ex("reset", 2'b00, 2'b00);
    chk("reset_stall", 16'(stall), 16'd0);
    chk("reset_cnt", stall_cnt, 16'd0);
    rst = 1'b0;

    // add x1 ; add x2,x1,x1
    present(5'd2, 5'd3, 5'd1, 1'b1, 1'b0);
    tick();
    present(5'd1, 5'd1, 5'd2, 1'b1, 1'b0);
    chk("exfwd_stall", 16'(stall), 16'd0);
    tick();
    chk_ex("exfwd", 2'b10, 2'b10);

    // add x1 ; nop ; sub x3,x1,x2
    present(5'd8, 5'd9, 5'd1, 1'b1, 1'b0);
    tick();
    present(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    present(5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    tick();
    chk_ex("wbfwd", 2'b01, 2'b00);

    // add x5 ; add x5 ; or x6,x5,x5
    present(5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
    tick();
    present(5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
    tick();
    present(5'd5, 5'd5, 5'd6, 1'b1, 1'b0);
    tick();
    chk_ex("prio", 2'b10, 2'b10);

    // lw x3 ; add x4,x3,x0
    present(5'd0, 5'd0, 5'd3, 1'b1, 1'b1);
    tick();
    present(5'd3, 5'd0, 5'd4, 1'b1, 1'b0);
    chk("lu_stall", 16'(stall), 16'd1);
    tick();
    chk_ex("lu_bubble", 2'b00, 2'b00);
    chk("lu_stall_clr", 16'(stall), 16'd0);
    chk("lu_cnt", stall_cnt, 16'd1);
    tick();
    chk_ex("lu_use", 2'b01, 2'b00);
    chk("lu_cnt_hold", stall_cnt, 16'd1);

    // addi x0 ; add x7,x0,x0 ; lw x0 ; use of x0
    present(5'd1, 5'd0, 5'd0, 1'b1, 1'b0);
    tick();
    present(5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
    tick();
    chk_ex("x0", 2'b00, 2'b00);
    present(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    tick();
    present(5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
    chk("x0_lw_stall", 16'(stall), 16'd0);
    tick();

    // lw x3 ; add x4,x3,x0 under flush
    present(5'd0, 5'd0, 5'd3, 1'b1, 1'b1);
    tick();
    present(5'd3, 5'd0, 5'd4, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    chk("flush_stall", 16'(stall), 16'd0);
    tick();
    flush = 1'b0;
    present(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    chk_ex("flush_bubble", 2'b00, 2'b00);
    chk("flush_cnt", stall_cnt, 16'd1);

    // asynchronous reset with forwards and a stall pending
    present(5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
    tick();
    present(5'd1, 5'd1, 5'd3, 1'b1, 1'b1);
    tick();
    chk_ex("pre_rst", 2'b10, 2'b10);
    present(5'd3, 5'd3, 5'd4, 1'b1, 1'b0);
    chk("pre_rst_stall", 16'(stall), 16'd1);
    rst = 1'b1;
    #1;
    chk_ex("async_rst", 2'b00, 2'b00);
    chk("async_rst_stall", 16'(stall), 16'd0);
    chk("async_rst_cnt", stall_cnt, 16'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_stall", 16'(stall), 16'd0);
    tick();
    chk_ex("post_rst", 2'b00, 2'b00);
    chk("post_rst_cnt", stall_cnt, 16'd0);

    // saturation: preload the counter close to the top, then stall three times
    present(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick();
    force dut.stall_cnt_q = 16'hFFFD;
    #1;
    release dut.stall_cnt_q;
    for (int i = 0; i < 3; i++) begin
      present(5'd0, 5'd0, 5'd3, 1'b1, 1'b1);
      tick();
      present(5'd3, 5'd0, 5'd4, 1'b1, 1'b0);
      chk($sformatf("sat_stall%0d", i), 16'(stall), 16'd1);
      tick();
      chk($sformatf("sat_cnt%0d", i), stall_cnt, (i == 0) ? 16'hFFFE : 16'hFFFF);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
